// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, receive FSM states, parity modes
// and a parity helper.
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 11;
  localparam int CNT_W      = $clog2(DATA_BITS);

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DATA      = 3'd1,
    PARITY    = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } uart_rx_state_t;

  // Expected parity bit for a data byte: even -> ^data, odd -> ~^data.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] data,
                                       input logic                 odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sipo_if.sv
// Byte handshake between the UART receive stage (master) and its consumer
// (slave): held byte, error flags qualified by rx_valid, and rx_ready.
interface uart_rx_sipo_if
  import uart_pkg::*;
();

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;

  modport master (
    output rx_data,
    output rx_valid,
    output parity_err,
    output frame_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  parity_err,
    input  frame_err,
    output rx_ready
  );

endinterface

// File: rtl/uart_sync.sv
// N-flop bit synchronizer for an asynchronous input. All stages reset to 1
// so an idle-high line does not look like a start bit coming out of reset.
module uart_sync #(
  parameter int N = 2
) (
  input  logic bd_clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [N-1:0] r_sync;

  // Shift the asynchronous input through the synchronizer chain.
  // NOTE: sequential state uses <= so every stage samples the pre-edge value of
  // its neighbour; blocking = here would collapse the chain into one flop.
  always_ff @(posedge bd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[N-2:0], i_d};
    end
  end

  assign o_q = r_sync[N-1];

endmodule

// File: rtl/uart_rx_sipo.sv
// UART receive stage: synchronizes rx, deserializes the 11-bit frame
// (start, 8 data LSB first, parity, stop), checks parity and stop bit and
// hands the byte out through a one-entry holding register.
// Optional parity checking is enabled by defining UART_RX_PARITY_CHECK_EN;
// without it the parity bit time is consumed and parity_err reads 0.
module uart_rx_sipo
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int PARITY_ODD  = PAR_EVEN
) (
  input  logic           bd_clk,
  input  logic           rst_n,
  input  logic           rx,
  input  logic           clr_ovr,
  output logic           overrun,
  output logic           busy,
  uart_rx_sipo_if.master rx_if
);

  // Reject configurations the synchronizer and parity logic do not support.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("uart_rx_sipo: SYNC_STAGES must be 2..4");
  end
  if (PARITY_ODD != PAR_EVEN && PARITY_ODD != PAR_ODD) begin : g_bad_par
    $error("uart_rx_sipo: PARITY_ODD must be 0 or 1");
  end

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  logic                 w_rx_s;
  uart_rx_state_t       r_state;
  uart_rx_state_t       w_next_state;
  logic [DATA_BITS-1:0] r_shreg;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_parity_err;
  logic                 r_frame_err;
  logic                 r_overrun;
  logic                 w_complete;
  logic                 w_accept;
  logic                 w_load;
  logic                 w_drop;
  logic                 w_parity_err;
  logic                 w_frame_err;

  uart_sync #(
    .N (SYNC_STAGES)
  ) u_rx_sync (
    .bd_clk (bd_clk),
    .rst_n  (rst_n),
    .i_d    (rx),
    .o_q    (w_rx_s)
  );

  // FSM state register.
  always_ff @(posedge bd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic; a stop bit of 0 parks in WAIT_HIGH until the line
  // recovers so a held-low break is not decoded as a stream of frames.
  // NOTE: w_next_state gets a default before the case so every path assigns
  // it; otherwise always_comb would infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:      if (!w_rx_s) w_next_state = DATA;
      DATA:      if (r_bit_cnt == LAST_BIT) w_next_state = PARITY;
      PARITY:    w_next_state = STOP;
      STOP:      w_next_state = w_rx_s ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (w_rx_s) w_next_state = IDLE;
      default:   w_next_state = IDLE;
    endcase
  end

  // Deserializer: shift data bits in LSB first and count them.
  always_ff @(posedge bd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_rx_s) r_bit_cnt <= '0;
        end
        DATA: begin
          r_shreg   <= {w_rx_s, r_shreg[DATA_BITS-1:1]};
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef UART_RX_PARITY_CHECK_EN
  logic r_par_bit;

  // Capture the received parity bit during its bit time.
  always_ff @(posedge bd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par_bit <= 1'b0;
    end else if (r_state == PARITY) begin
      r_par_bit <= w_rx_s;
    end
  end

  assign w_parity_err = r_par_bit ^ calc_parity(r_shreg, 1'(PARITY_ODD));
`else
  assign w_parity_err = 1'b0;
`endif

  assign w_complete  = (r_state == STOP);
  assign w_frame_err = ~w_rx_s;
  assign w_accept    = r_valid & rx_if.rx_ready;
  assign w_load      = w_complete & (~r_valid | w_accept);
  assign w_drop      = w_complete & r_valid & ~w_accept;

  // Holding register: load on completion when empty or being drained,
  // otherwise clear on accept; contents stay frozen while valid.
  always_ff @(posedge bd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else if (w_load) begin
      r_data       <= r_shreg;
      r_valid      <= 1'b1;
      r_parity_err <= w_parity_err;
      r_frame_err  <= w_frame_err;
    end else if (w_accept) begin
      r_valid      <= 1'b0;
    end
  end

  // Sticky overrun: set by a dropped frame, cleared by clr_ovr, set wins.
  always_ff @(posedge bd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (clr_ovr) begin
      r_overrun <= 1'b0;
    end
  end

  assign rx_if.rx_data    = r_data;
  assign rx_if.rx_valid   = r_valid;
  assign rx_if.parity_err = r_parity_err;
  assign rx_if.frame_err  = r_frame_err;
  assign overrun          = r_overrun;
  assign busy             = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Directed testbench for uart_rx_sipo with hand-computed expectations.
module tb_uart_rx_sipo;
  import uart_pkg::*;

  logic bd_clk = 1'b0;
  logic rst_n;
  logic rx;
  logic clr_ovr;
  logic overrun;
  logic busy;

  int n_cmp = 0;
  int n_mis = 0;

`ifdef UART_RX_PARITY_CHECK_EN
  localparam logic EXP_BAD_PAR = 1'b1;
`else
  localparam logic EXP_BAD_PAR = 1'b0;
`endif

  uart_rx_sipo_if rx_if ();

  uart_rx_sipo #(
    .SYNC_STAGES (2),
    .PARITY_ODD  (0)
  ) dut (
    .bd_clk  (bd_clk),
    .rst_n   (rst_n),
    .rx      (rx),
    .clr_ovr (clr_ovr),
    .overrun (overrun),
    .busy    (busy),
    .rx_if   (rx_if)
  );

  always #5 bd_clk = ~bd_clk;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge bd_clk);
    #1;
  endtask

  function automatic logic [FRAME_BITS-1:0] build(input logic [7:0] d, input logic p,
                                                  input logic s);
    return {s, p, d, 1'b0};
  endfunction

  // Drives one frame, one bit per cycle; the start bit is captured at the
  // first edge (k) and the task returns 1 ns after edge k+10.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    logic [FRAME_BITS-1:0] f;
    f = build(d, p, s);
    for (int i = 0; i < FRAME_BITS; i++) begin
      rx = f[i];
      tick();
    end
  endtask

  task automatic accept_pulse();
    rx_if.rx_ready = 1'b1;
    tick();
    rx_if.rx_ready = 1'b0;
  endtask

  initial begin
    int cnt;
    logic [FRAME_BITS-1:0] fp;

    rst_n = 1'b0;
    rx = 1'b1;
    clr_ovr = 1'b0;
    rx_if.rx_ready = 1'b0;
    repeat (3) tick();

    // Reset state.
    check("rst_valid", rx_if.rx_valid, 0);
    check("rst_data", rx_if.rx_data, 0);
    check("rst_perr", rx_if.parity_err, 0);
    check("rst_ferr", rx_if.frame_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // 0xA5, correct even parity, good stop: valid at k+12, not k+11.
    send_frame(8'hA5, 1'b0, 1'b1);
    tick();
    check("a5_valid_k11", rx_if.rx_valid, 0);
    check("a5_busy_k11", busy, 1);
    tick();
    check("a5_valid_k12", rx_if.rx_valid, 1);
    check("a5_data", rx_if.rx_data, 8'hA5);
    check("a5_perr", rx_if.parity_err, 0);
    check("a5_ferr", rx_if.frame_err, 0);
    check("a5_busy_after", busy, 0);
    tick();
    check("a5_hold_data", rx_if.rx_data, 8'hA5);
    accept_pulse();
    check("a5_drained", rx_if.rx_valid, 0);

    // 0x01 with parity bit 0 (wrong for even): byte still delivered.
    send_frame(8'h01, 1'b0, 1'b1);
    repeat (2) tick();
    check("p01_valid", rx_if.rx_valid, 1);
    check("p01_data", rx_if.rx_data, 8'h01);
    check("p01_perr", rx_if.parity_err, 32'(EXP_BAD_PAR));
    check("p01_ferr", rx_if.frame_err, 0);
    accept_pulse();

    // 0x3C with stop 0, line then held low: frame error, parked in WAIT_HIGH.
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (2) tick();
    check("f3c_valid", rx_if.rx_valid, 1);
    check("f3c_data", rx_if.rx_data, 8'h3C);
    check("f3c_ferr", rx_if.frame_err, 1);
    check("f3c_perr", rx_if.parity_err, 0);
    accept_pulse();
    check("f3c_drained", rx_if.rx_valid, 0);
    cnt = 0;
    for (int i = 0; i < 17; i++) begin
      tick();
      if (rx_if.rx_valid) cnt++;
    end
    check("brk_no_valid", cnt, 0);
    check("brk_busy", busy, 1);
    rx = 1'b1;
    repeat (4) tick();
    check("brk_exit_busy", busy, 0);
    check("brk_exit_valid", rx_if.rx_valid, 0);
    repeat (2) tick();

    // 0x11 then 0x22 back-to-back, no ready: 0x22 dropped, overrun set.
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    repeat (2) tick();
    check("ovr_valid", rx_if.rx_valid, 1);
    check("ovr_data", rx_if.rx_data, 8'h11);
    check("ovr_flag", overrun, 1);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    check("ovr_cleared", overrun, 0);
    check("ovr_data_kept", rx_if.rx_data, 8'h11);
    accept_pulse();
    check("ovr_drained", rx_if.rx_valid, 0);
    repeat (2) tick();

    // Ready exactly in the 0x22 completion cycle: 0x22 replaces 0x33, no drop.
    send_frame(8'h33, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    tick();
    check("rdy_old_data", rx_if.rx_data, 8'h33);
    rx_if.rx_ready = 1'b1;
    tick();
    rx_if.rx_ready = 1'b0;
    check("rdy_valid", rx_if.rx_valid, 1);
    check("rdy_data", rx_if.rx_data, 8'h22);
    check("rdy_ovr", overrun, 0);
    accept_pulse();
    check("rdy_drained", rx_if.rx_valid, 0);
    repeat (2) tick();

    // Reset after 4 data bits of 0x5A; frame must be abandoned.
    fp = build(8'h5A, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      rx = fp[i];
      tick();
    end
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", rx_if.rx_valid, 0);
    check("mid_rst_data", rx_if.rx_data, 0);
    check("mid_rst_ovr", overrun, 0);
    tick();
    rx = 1'b1;
    tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (rx_if.rx_valid || busy) cnt++;
    end
    check("mid_no_partial", cnt, 0);

    // 0x5A with ready held high: byte visible for exactly one cycle.
    rx_if.rx_ready = 1'b1;
    send_frame(8'h5A, 1'b0, 1'b1);
    tick();
    check("5a_valid_k11", rx_if.rx_valid, 0);
    tick();
    check("5a_valid_k12", rx_if.rx_valid, 1);
    check("5a_data", rx_if.rx_data, 8'h5A);
    tick();
    check("5a_one_cycle", rx_if.rx_valid, 0);
    rx_if.rx_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/uart_rx_sipo.md
# uart_rx_sipo

Serial-in/parallel-out receive stage of the UART. Consumes the 11-bit frame our transmit stage drives on the line (start 0, 8 data bits LSB first, parity, stop 1), one bit per `bd_clk`. It synchronizes the line, deserializes the frame, checks parity and stop bit, and presents the byte through a one-entry holding register with a valid/ready handshake.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer flops on `rx`; legal values are 2–4.
- `PARITY_ODD`, default 0: 0 selects even parity (parity bit = ^data); 1 selects odd parity (parity bit = ~^data).

Ports:
- `bd_clk`  in  1: bit clock, one bit period per cycle.
- `rst_n`  in  1: asynchronous, active-low reset.
- `rx`  in  1: serial line; idles high; asynchronous to `bd_clk`.
- `rx_ready`  in  1: consumer accepts the held byte.
- `clr_ovr`  in  1: clears `overrun`.
- `rx_data`  out  8: received byte.
- `rx_valid`  out  1: holding register full.
- `parity_err`  out  1: parity mismatch on the held byte; qualified by `rx_valid`.
- `frame_err`  out  1: stop bit was 0 on the held byte; qualified by `rx_valid`.
- `overrun`  out  1: sticky; a completed frame was dropped.
- `busy`  out  1: high in any state other than IDLE.

## Operation
- `rx_s` is the last synchronizer stage. All synchronizer flops reset to 1.
- State machine states: IDLE, DATA, PARITY, STOP, WAIT_HIGH.
- **IDLE:** if `rx_s`=0, the start bit is consumed, `bit_cnt`←0 and the FSM goes to DATA. Otherwise it stays in IDLE.
- **DATA:** each cycle `shreg` ← {`rx_s`, `shreg[7:1]`} and `bit_cnt`++. After the 8th bit (`bit_cnt`==7) it goes to PARITY.
- **PARITY:** latch `rx_s` as `par_bit`, then go to STOP.
- **STOP:** sample the stop bit and complete the frame.
  - If the stop bit = 1, go to IDLE. A start bit in the very next cycle is accepted (zero idle gap supported).
  - If the stop bit = 0, go to WAIT_HIGH.
- **WAIT_HIGH:** stay until `rx_s`=1, then go to IDLE. This prevents a held-low line (break) from being decoded as repeated frames.
- **Frame completion** (STOP cycle), with `accept` = `rx_valid` & `rx_ready`:
  - If `rx_valid`=0 or `accept`=1, load `rx_data`←`shreg`, `parity_err`, `frame_err`, and set `rx_valid`←1.
  - Otherwise discard the new frame, keep the old contents, and set `overrun`←1.
- **Parity check:** `parity_err` = `par_bit` ^ (^`shreg`) ^ `PARITY_ODD`.
- **Handshake:** `accept` without a completion in the same cycle clears `rx_valid` next cycle. `rx_data`, `parity_err` and `frame_err` stay stable while `rx_valid`=1.
- **Overrun:** `overrun` is set by a drop and cleared by `clr_ovr`. If both happen in the same cycle, set wins.
- **Reset values:** `rx_data`=0, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `overrun`=0, `busy`=0, FSM=IDLE, `shreg`=0, `bit_cnt`=0. Reset mid-frame abandons the frame with no partial output.

## Timing
- The start bit is first captured by the synchronizer at edge k. `rx_valid` rises after edge k+`SYNC_STAGES`+10 (k+12 with the default). The transmit-to-valid latency is therefore frame length + `SYNC_STAGES` − 1 cycles.
- `busy` rises one cycle after IDLE sees `rx_s`=0. It falls the cycle after STOP, or the cycle after WAIT_HIGH exits.
- A continuous stream of back-to-back frames yields one `rx_valid` completion every 11 cycles.
- `rx_ready` may be held high permanently. Each byte is then visible for exactly one cycle per frame.

## Configuration
- Macro `UART_RX_PARITY_CHECK_EN`.
  - Defined: PARITY state, `par_bit` and the parity check are implemented as described above.
  - Undefined: the PARITY state still consumes one bit time so the frame length stays 11, but the bit is discarded. `parity_err` is tied to 0 and `PARITY_ODD` is ignored.

## Structure
- Shared package `uart_pkg`:
  - `DATA_BITS`=8 and `FRAME_BITS`=11.
  - State enum `uart_rx_state_t` (IDLE, DATA, PARITY, STOP, WAIT_HIGH).
  - Parity-mode constants `PAR_EVEN`=0 and `PAR_ODD`=1.
- Sub-module `uart_sync`: a parameterized N-flop bit synchronizer with reset value 1. It is instantiated once for `rx`.

## Test plan
- Reset, then byte 0xA5 with even parity bit 0 and stop 1 → `rx_data`=0xA5, `rx_valid` rises at edge k+12, `parity_err`=0, `frame_err`=0.
- Byte 0x01 with parity bit 0 (wrong for even) → `parity_err`=1, byte still delivered. With the macro undefined → `parity_err`=0.
- Byte 0x3C with stop bit 0, then line held low for 20 cycles → `frame_err`=1 with 0x3C, FSM stays in WAIT_HIGH, no further `rx_valid` until the line returns high.
- Frames 0x11 and 0x22 back-to-back with `rx_ready`=0 → 0x11 held, `overrun`=1. Then `clr_ovr` pulse → `overrun`=0 and `rx_data` is still 0x11.
- `rx_ready` asserted exactly in the 0x22 completion cycle → 0x22 loaded, `rx_valid` stays 1, `overrun` stays 0.
- `rst_n` asserted after 4 data bits, released, then frame 0x5A → all outputs at reset values during reset; only 0x5A is delivered afterwards.
